// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM measurement block: FSM state encoding and
// the default counter width.
package pwm_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StMeas = 2'd2
  } pwm_state_e;

  localparam int unsigned CntWDefault = 32;

endpackage

// File: rtl/pwm_sync_filt.sv
// Input conditioning for the PWM measurement block: 2-flop synchronizer,
// optional glitch filter (PWM_MEAS_FILTER_EN) and a registered rising-edge
// detector on the resulting level.
module pwm_sync_filt #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pwm,
  output logic o_level,
  output logic o_rise
);

  // A zero-length filter has no meaning; catch it at elaboration.
  if (FILT_LEN == 0) begin : g_filt_len_chk
    $error("FILT_LEN must be at least 1");
  end

  logic sync1_q, sync2_q;
  logic level;
  logic level_dly_q;

  // Two-stage synchronizer for the asynchronous PWM input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_pwm;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_MEAS_FILTER_EN
  localparam int unsigned FiltCntW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [FiltCntW-1:0] filt_cnt_d, filt_cnt_q;
  logic                filt_d, filt_q;

  // Flip the filtered level only after FILT_LEN consecutive differing samples.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (filt_cnt_q == FiltCntW'(FILT_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q     <= 1'b0;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  // Delayed copy of the level for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_dly_q <= 1'b0;
    end else begin
      level_dly_q <= level;
    end
  end

  assign o_level = level;
  assign o_rise  = level & ~level_dly_q;

endmodule

// File: rtl/pwm_meas.sv
// PWM period / high-time measurement. Measures rise-to-rise period and high
// time in clocks, counts complete periods and flags missing edges with a
// programmable timeout. Optional input glitch filter: define PWM_MEAS_FILTER_EN.
module pwm_meas
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W    = CntWDefault,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_pwm,
  input  logic [CNT_W-1:0] i_timeout,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic [15:0]      o_pulses,
  output logic             o_valid,
  output logic             o_timeout,
  output logic             o_busy
);

  logic level, rise;

  pwm_sync_filt #(
    .FILT_LEN(FILT_LEN)
  ) u_sync_filt (
    .clk    (clk),
    .rst    (rst),
    .i_pwm  (i_pwm),
    .o_level(level),
    .o_rise (rise)
  );

  pwm_state_e       state_d, state_q;
  logic [CNT_W-1:0] period_d, period_q;
  logic [CNT_W-1:0] high_d, high_q;
  logic [CNT_W-1:0] since_d, since_q;
  logic [CNT_W-1:0] period_out_d, period_out_q;
  logic [CNT_W-1:0] high_out_d, high_out_q;
  logic [15:0]      pulses_d, pulses_q;
  logic             valid_d, valid_q;
  logic             timeout_d, timeout_q;

  logic [CNT_W-1:0] period_inc, high_inc, since_inc;
  logic             tmo_hit;

  // Saturating increments and timeout detection.
  always_comb begin
    period_inc = (period_q == '1) ? period_q : period_q + 1'b1;
    high_inc   = (high_q == '1) ? high_q : high_q + 1'b1;
    since_inc  = (since_q == '1) ? since_q : since_q + 1'b1;
    tmo_hit    = (i_timeout != '0) && (since_inc >= i_timeout);
  end

  // Next-state logic: FSM, measurement counters and result registers.
  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    high_d       = high_q;
    since_d      = since_q;
    period_out_d = period_out_q;
    high_out_d   = high_out_q;
    pulses_d     = pulses_q;
    valid_d      = 1'b0;
    timeout_d    = 1'b0;

    if (!i_en) begin
      state_d  = StIdle;
      period_d = '0;
      high_d   = '0;
      since_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StArm;
          pulses_d = '0;
          period_d = '0;
          high_d   = '0;
          since_d  = '0;
        end
        StArm: begin
          if (rise) begin
            state_d  = StMeas;
            period_d = CNT_W'(1);
            high_d   = CNT_W'(1);
            since_d  = '0;
          end else if (tmo_hit) begin
            timeout_d = 1'b1;
            since_d   = '0;
          end else begin
            since_d = since_inc;
          end
        end
        StMeas: begin
          if (rise) begin
            // Rise has priority over a coincident timeout.
            period_out_d = period_q;
            high_out_d   = high_q;
            valid_d      = 1'b1;
            pulses_d     = (pulses_q == 16'hFFFF) ? pulses_q : pulses_q + 16'd1;
            period_d     = CNT_W'(1);
            high_d       = CNT_W'(1);
            since_d      = '0;
          end else if (tmo_hit) begin
            timeout_d = 1'b1;
            state_d   = StArm;
            period_d  = '0;
            high_d    = '0;
            since_d   = '0;
          end else begin
            period_d = period_inc;
            high_d   = level ? high_inc : high_q;
            since_d  = since_inc;
          end
        end
        default: begin
          state_d  = StIdle;
          period_d = '0;
          high_d   = '0;
          since_d  = '0;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      period_q     <= '0;
      high_q       <= '0;
      since_q      <= '0;
      period_out_q <= '0;
      high_out_q   <= '0;
      pulses_q     <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      high_q       <= high_d;
      since_q      <= since_d;
      period_out_q <= period_out_d;
      high_out_q   <= high_out_d;
      pulses_q     <= pulses_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign o_period  = period_out_q;
  assign o_high    = high_out_q;
  assign o_pulses  = pulses_q;
  assign o_valid   = valid_q;
  assign o_timeout = timeout_q;
  assign o_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_pwm_meas.sv
// Self-checking bench for pwm_meas (default build, filter disabled).
// A timestamp-based reference model predicts every output on every clock.
module tb_pwm_meas;

  localparam int unsigned CW       = 32;
  localparam int          MaxEdges = 65536;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_en = 1'b0;
  logic          i_pwm = 1'b0;
  logic [CW-1:0] i_timeout = '0;
  logic [CW-1:0] o_period, o_high;
  logic [15:0]   o_pulses;
  logic          o_valid, o_timeout, o_busy;

  pwm_meas #(
    .CNT_W   (CW),
    .FILT_LEN(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_en     (i_en),
    .i_pwm    (i_pwm),
    .i_timeout(i_timeout),
    .o_period (o_period),
    .o_high   (o_high),
    .o_pulses (o_pulses),
    .o_valid  (o_valid),
    .o_timeout(o_timeout),
    .o_busy   (o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: input history by edge index, phase and timestamps.
  bit          hist[MaxEdges];
  int          edge_cnt = 0;
  int          floor_e  = 0;   // history before this edge reads as 0 (flushed by reset)
  int          phase    = 0;   // 0 idle, 1 waiting for first rise, 2 measuring
  int          prev_rise = 0;
  int          ref_e    = 0;   // last rise, arm entry or timeout
  logic [31:0] m_period = '0, m_high = '0;
  int          m_pulses = 0;
  bit          m_valid  = 1'b0, m_tmo = 1'b0;
  int          n_valid  = 0, n_tmo = 0;

  // Level seen by the measurement logic lags the pin by two edges.
  function automatic bit lv(input int idx);
    if (idx < 0 || idx < floor_e) return 1'b0;
    return hist[idx];
  endfunction

  initial begin : monitor
    int          e, hsum;
    bit          en, rs, rise;
    logic [31:0] t;
    forever begin
      @(posedge clk);
      e  = edge_cnt;
      rs = rst;
      en = i_en;
      t  = i_timeout;
      if (e < MaxEdges) hist[e] = i_pwm;
      edge_cnt++;
      m_valid = 1'b0;
      m_tmo   = 1'b0;
      if (!rs) begin
        floor_e  = e + 1;
        phase    = 0;
        m_period = '0;
        m_high   = '0;
        m_pulses = 0;
      end else begin
        rise = lv(e - 2) && !lv(e - 3);
        if (!en) begin
          phase = 0;
        end else if (phase == 0) begin
          phase    = 1;
          m_pulses = 0;
          ref_e    = e;
        end else if (rise) begin
          if (phase == 2) begin
            m_valid  = 1'b1;
            m_period = 32'(e - prev_rise);
            hsum = 0;
            for (int j = prev_rise - 2; j <= e - 3; j++) hsum += int'(lv(j));
            m_high = 32'(hsum);
            if (m_pulses < 65535) m_pulses++;
          end
          phase     = 2;
          prev_rise = e;
          ref_e     = e;
        end else if (t != 0 && longint'(e - ref_e) >= longint'(t)) begin
          m_tmo = 1'b1;
          phase = 1;
          ref_e = e;
        end
      end
      #1;
      if (o_valid) n_valid++;
      if (o_timeout) n_tmo++;
      check_eq("valid", o_valid, m_valid);
      check_eq("timeout", o_timeout, m_tmo);
      check_eq("busy", o_busy, phase != 0);
      check_eq("pulses", o_pulses, m_pulses);
      check_eq("period", o_period, m_period);
      check_eq("high", o_high, m_high);
    end
  end

  task automatic hold(input int n, input bit lvl);
    repeat (n) begin
      @(negedge clk);
      i_pwm = lvl;
    end
  endtask

  task automatic pwm(input int per, input int hi, input int n);
    repeat (n) begin
      hold(hi, 1'b1);
      hold(per - hi, 1'b0);
    end
  endtask

  initial begin : stimulus
    int v0, t0, per, hi;
    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("rst_period", o_period, 0);
    check_eq("rst_busy", o_busy, 0);
    rst = 1'b1;

    // Regular waveform, timeout disabled.
    @(negedge clk);
    i_en = 1'b1;
    hold(5, 1'b0);
    v0 = n_valid;
    pwm(10, 3, 5);
    hold(30, 1'b0);
    check_eq("p10_valids", n_valid - v0, 4);
    check_eq("p10_pulses", o_pulses, 4);
    check_eq("p10_period", o_period, 10);
    check_eq("p10_high", o_high, 3);

    // Near-100% duty, then constant high.
    pwm(1000, 999, 3);
    hold(10, 1'b1);
    check_eq("p1000_period", o_period, 1000);
    check_eq("p1000_high", o_high, 999);
    v0 = n_valid;
    hold(290, 1'b1);
    check_eq("const_high_valids", n_valid - v0, 0);

    // Timeout after the input stops toggling.
    hold(5, 1'b0);
    i_timeout = 50;
    pwm(20, 5, 2);
    t0 = n_tmo;
    hold(40, 1'b0);
    check_eq("tmo_once", n_tmo - t0, 1);
    check_eq("tmo_busy", o_busy, 1);
    check_eq("tmo_period", o_period, 20);
    i_timeout = 0;

    // Enable dropped mid-period.
    pwm(10, 3, 3);
    hold(2, 1'b1);
    i_en = 1'b0;
    hold(3, 1'b0);
    i_en = 1'b1;
    v0 = n_valid;
    hold(3, 1'b0);
    check_eq("reen_pulses", o_pulses, 0);
    pwm(10, 3, 1);
    check_eq("reen_arm_valids", n_valid - v0, 0);
    pwm(10, 3, 1);
    check_eq("reen_first_valids", n_valid - v0, 1);
    check_eq("reen_period", o_period, 10);

    // Asynchronous reset mid-measurement.
    pwm(10, 3, 2);
    hold(2, 1'b1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_eq("arst_period", o_period, 0);
    check_eq("arst_high", o_high, 0);
    check_eq("arst_pulses", o_pulses, 0);
    check_eq("arst_busy", o_busy, 0);
    hold(2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    v0 = n_valid;
    pwm(10, 3, 1);
    check_eq("arst_arm_valids", n_valid - v0, 0);
    pwm(10, 3, 1);
    hold(3, 1'b0);
    check_eq("arst_first_valids", n_valid - v0, 1);

    // Randomized segments checked cycle-by-cycle against the model.
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(3, 0) == 0)
        i_timeout = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(80, 5);
      if ($urandom_range(5, 0) == 0) begin
        i_en = 1'b0;
        hold($urandom_range(5, 1), 1'($urandom_range(1, 0)));
        i_en = 1'b1;
      end
      case ($urandom_range(3, 0))
        0: hold($urandom_range(100, 1), 1'($urandom_range(1, 0)));
        1: repeat ($urandom_range(50, 10)) hold(1, 1'($urandom_range(1, 0)));
        default: begin
          per = $urandom_range(40, 2);
          hi  = $urandom_range(per - 1, 1);
          pwm(per, hi, $urandom_range(6, 1));
        end
      endcase
    end
    hold(5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_meas.md
PWM_MEAS -- requirements
Module: pwm_meas

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of period/high/timeout counters.
REQ-002 SHALL have parameter FILT_LEN, default 4, glitch-filter stability length in clocks (used only with PWM_MEAS_FILTER_EN).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_en  input  1  measurement enable, level-sensitive.
REQ-006 SHALL have port i_pwm  input  1  asynchronous PWM waveform under measurement.
REQ-007 SHALL have port i_timeout  input  CNT_W  max clocks without a rising edge; 0 disables timeout.
REQ-008 SHALL have port o_period  output  CNT_W  last measured period in clocks.
REQ-009 SHALL have port o_high  output  CNT_W  last measured high time in clocks.
REQ-010 SHALL have port o_pulses  output  16  complete periods measured since enable.
REQ-011 SHALL have port o_valid  output  1  one-cycle strobe: o_period/o_high updated.
REQ-012 SHALL have port o_timeout  output  1  one-cycle strobe: timeout fired.
REQ-013 SHALL have port o_busy  output  1  high when state is not IDLE.

Function
REQ-014 SHALL pass i_pwm through a 2-flop synchronizer, then a registered rising-edge detector (rise = sync & ~sync_d).
REQ-015 SHALL implement states IDLE, ARM, MEAS.
REQ-016 IDLE: counters held at 0; i_en=1 -> ARM, o_pulses cleared to 0 on this transition.
REQ-017 ARM: waits for first rise; rise -> MEAS with period counter=1, high counter=1; no o_valid.
REQ-018 MEAS: period counter +1 every cycle; high counter +1 each cycle synchronized level is 1.
REQ-019 MEAS on rise: o_period<=period counter, o_high<=high counter, o_valid=1 for one cycle, o_pulses+1, counters reload to 1.
REQ-020 Latency: i_pwm first sampled high at edge N -> o_valid high after edge N+2 (filter off).
REQ-021 Period/high counters SHALL saturate at all-ones, never wrap; o_pulses SHALL saturate at 16'hFFFF.
REQ-022 In ARM or MEAS, cycles since last rise (or ARM entry) reaching i_timeout (i_timeout!=0) -> o_timeout one cycle, state ARM, counters 0; o_period/o_high/o_pulses retained.
REQ-023 Rise and timeout in same cycle: rise wins, no o_timeout.
REQ-024 i_en=0 in any state -> IDLE next cycle, no o_valid; o_period/o_high/o_pulses retained until next enable.
REQ-025 Constant-high or constant-low input SHALL produce only timeouts, never o_valid.

Reset
REQ-026 rst=0 SHALL asynchronously force state IDLE, synchronizer/filter flops 0, all counters 0, all outputs 0.
REQ-027 Reset mid-measurement SHALL discard partial counts; first period after release requires a new ARM rise.

Configuration
REQ-028 Macro PWM_MEAS_FILTER_EN defined: synchronized level changes only after FILT_LEN consecutive equal samples; latency grows by FILT_LEN clocks; pulses shorter than FILT_LEN ignored.
REQ-029 PWM_MEAS_FILTER_EN undefined: synchronizer output used directly; FILT_LEN unused, no filter logic.

Structure
REQ-030 Shared package pwm_pkg SHALL hold state encoding (IDLE=2'd0, ARM=2'd1, MEAS=2'd2) and default counter width constant 32.
REQ-031 Synchronizer plus optional filter SHALL be sub-module pwm_sync_filt; FSM, counters, outputs in pwm_meas.

Verification
REQ-032 Enable, i_timeout=0, i_pwm period 10 high 3, 5 periods -> 4 o_valid strobes, each o_period=10, o_high=3, final o_pulses=4.
REQ-033 Period 1000 high 999 -> o_period=1000, o_high=999; then 100% high -> no o_valid.
REQ-034 i_timeout=50, i_pwm held low after 2 periods -> o_timeout once 50 clocks after last rise, state ARM, o_period unchanged.
REQ-035 Drop i_en mid-period, reassert -> no o_valid for partial period, o_pulses restarts at 0, first o_valid only after ARM rise plus full period.
REQ-036 Assert rst mid-MEAS asynchronously -> all outputs 0 immediately, o_busy=0; post-release first valid needs two rises.
REQ-037 With PWM_MEAS_FILTER_EN, FILT_LEN=4: 2-clock glitch on low input -> no edge; clean period 20 high 8 -> o_period=20, o_high=8.
